mesh_term_injector: RTL and testbench

//  Terminal-side source interface for one edge port of mesh_gnrtr (upstream of the router input).

---
 rtl/mesh_term_injector.sv | 147 ++++++++++++++
 tb/tb_mesh_term_injector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mesh_term_injector.sv
`default_nettype none
// mesh_term_injector: terminal-side source that validates host requests, builds mesh headers and queues them for the router.
// Revision: 1.0

module mesh_term_injector #(
  parameter int         ROWS       = 4,
  parameter int         COLUMNS    = 4,
  parameter int         PAKG_SIZE  = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter int         MY_ROW     = 0,
  parameter int         MY_COL     = 1,
  parameter logic [7:0] BDCST      = 8'hFF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [3:0]                    req_row_i,
  input  logic [3:0]                    req_col_i,
  input  logic                          req_mode_i,
  input  logic                          req_bcst_i,
  input  logic [PAKG_SIZE-18:0]         req_payload_i,
  output logic                          pndng_o,
  output logic [PAKG_SIZE-1:0]          data_out_o,
  input  logic                          popin_i,
  output logic                          drop_o,
  output logic [15:0]                   drop_cnt_o,
  output logic [15:0]                   sent_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam int         CW         = AW + 1;
  localparam logic [CW-1:0] c_FULL  = CW'(FIFO_DEPTH);
  localparam logic [3:0] c_ROW_LAST = 4'(ROWS + 1);
  localparam logic [3:0] c_COL_LAST = 4'(COLUMNS + 1);
  localparam logic [3:0] c_ROWS     = 4'(ROWS);
  localparam logic [3:0] c_COLS     = 4'(COLUMNS);
  localparam logic [3:0] c_MY_ROW   = 4'(MY_ROW);
  localparam logic [3:0] c_MY_COL   = 4'(MY_COL);

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_PENDING = 1'b1} state_t;

  state_t                 r_state;
  logic [PAKG_SIZE-1:0]   r_mem [FIFO_DEPTH];
  logic [PAKG_SIZE-1:0]   r_data;
  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_tail;
  logic [CW-1:0]          r_count;
  logic                   r_drop;
  logic [15:0]            r_drop_cnt;
  logic [15:0]            r_sent_cnt;

  logic                   w_push;
  logic                   w_row_edge;
  logic                   w_col_edge;
  logic                   w_row_in;
  logic                   w_col_in;
  logic                   w_self;
  logic                   w_valid;
  logic                   w_wr;
  logic                   w_pop;
  logic [7:0]             w_dest;
  logic [PAKG_SIZE-1:0]   w_word;
  logic [AW-1:0]          w_head_nxt;
  logic [CW-1:0]          w_cnt_after_pop;
  logic [CW-1:0]          w_cnt_nxt;

  assign req_ready_o = (r_count != c_FULL);
  assign w_push      = req_valid_i & req_ready_o;

  // Destinations must be edge terminals (corners excluded) and not this terminal itself.
  assign w_row_edge = (req_row_i == 4'd0) || (req_row_i == c_ROW_LAST);
  assign w_col_edge = (req_col_i == 4'd0) || (req_col_i == c_COL_LAST);
  assign w_row_in   = (req_row_i != 4'd0) && (req_row_i <= c_ROWS);
  assign w_col_in   = (req_col_i != 4'd0) && (req_col_i <= c_COLS);
  assign w_self     = (req_row_i == c_MY_ROW) && (req_col_i == c_MY_COL);
  assign w_valid    = req_bcst_i | (((w_row_edge & w_col_in) | (w_col_edge & w_row_in)) & ~w_self);

  assign w_dest = req_bcst_i ? BDCST : {req_row_i, req_col_i};
  assign w_word = {8'h00, w_dest, req_mode_i, req_payload_i};

  assign w_wr            = w_push & w_valid;
  assign w_pop           = popin_i & (r_state == S_PENDING);
  assign w_head_nxt      = w_pop ? r_head + AW'(1) : r_head;
  assign w_cnt_after_pop = r_count - CW'(w_pop);
  assign w_cnt_nxt       = w_cnt_after_pop + CW'(w_wr);

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_tail] <= w_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_EMPTY;
      r_data     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
      r_sent_cnt <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_count <= w_cnt_nxt;
      r_drop  <= w_push & ~w_valid;
      if (w_wr) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_push && !w_valid && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_pop && r_sent_cnt != 16'hFFFF) begin
        r_sent_cnt <= r_sent_cnt + 16'd1;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_wr) begin
            r_state <= S_PENDING;
            r_data  <= w_word;
          end
        end
        S_PENDING: begin
          if (w_cnt_nxt == '0) begin
            r_state <= S_EMPTY;
          end else if (w_pop) begin
            // The new head may be the word being written this very cycle.
            r_data <= (w_cnt_after_pop == '0) ? w_word : r_mem[w_head_nxt];
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign pndng_o    = (r_state == S_PENDING);
  assign data_out_o = r_data;
  assign drop_o     = r_drop;
  assign drop_cnt_o = r_drop_cnt;
  assign sent_cnt_o = r_sent_cnt;
  assign count_o    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mesh_term_injector.sv
`default_nettype none
// tb_mesh_term_injector: directed plus randomized checks against a queue-based reference model.
// Revision: 1.0

module tb_mesh_term_injector;

  localparam int ROWS = 4, COLUMNS = 4, PS = 32, DEPTH = 16, MY_ROW = 0, MY_COL = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_mode, req_bcst, popin;
  logic [3:0]  req_row, req_col;
  logic [14:0] req_payload;
  logic        pndng, drop;
  logic [31:0] data_out;
  logic [15:0] drop_cnt, sent_cnt;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  logic        exp_drop;
  logic [15:0] exp_dropc, exp_sent;

  always #5 clk = ~clk;

  mesh_term_injector #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .PAKG_SIZE(PS), .FIFO_DEPTH(DEPTH),
    .MY_ROW(MY_ROW), .MY_COL(MY_COL), .BDCST(8'hFF)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_row_i(req_row), .req_col_i(req_col),
    .req_mode_i(req_mode), .req_bcst_i(req_bcst), .req_payload_i(req_payload),
    .pndng_o(pndng), .data_out_o(data_out), .popin_i(popin),
    .drop_o(drop), .drop_cnt_o(drop_cnt), .sent_cnt_o(sent_cnt), .count_o(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_terminal(input int r, input int c);
    bit on_row_edge = (r == 0 || r == ROWS + 1) && (c >= 1 && c <= COLUMNS);
    bit on_col_edge = (c == 0 || c == COLUMNS + 1) && (r >= 1 && r <= ROWS);
    return on_row_edge || on_col_edge;
  endfunction

  task automatic check_all();
    chk("pndng", 32'(pndng), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("data_out", data_out, mq[0]);
    chk("count", 32'(count), 32'(mq.size()));
    chk("ready", 32'(req_ready), 32'(mq.size() != DEPTH));
    chk("drop", 32'(drop), 32'(exp_drop));
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_dropc));
    chk("sent_cnt", 32'(sent_cnt), 32'(exp_sent));
  endtask

  // Advance the model by one clock using the inputs presently applied, then compare.
  task automatic cycle();
    bit xfer, ok, pop;
    xfer = req_valid && (mq.size() < DEPTH);
    pop  = popin && (mq.size() > 0);
    ok   = req_bcst || (is_terminal(int'(req_row), int'(req_col)) &&
                        !(int'(req_row) == MY_ROW && int'(req_col) == MY_COL));
    exp_drop = xfer && !ok;
    if (pop) begin
      void'(mq.pop_front());
      if (exp_sent != 16'hFFFF) exp_sent++;
    end
    if (xfer && ok)
      mq.push_back({8'h00, (req_bcst ? 8'hFF : {req_row, req_col}), req_mode, req_payload});
    if (exp_drop && exp_dropc != 16'hFFFF) exp_dropc++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input int r, input int c, input bit m, input bit b,
                       input logic [14:0] p, input bit pop);
    req_valid = v; req_row = 4'(r); req_col = 4'(c); req_mode = m; req_bcst = b;
    req_payload = p; popin = pop;
    cycle();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 15'h0, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 0; req_row = 0; req_col = 0; req_mode = 0; req_bcst = 0;
    req_payload = 0; popin = 0;
    exp_drop = 0; exp_dropc = 0; exp_sent = 0;
    #1;
    chk("rst_pndng", 32'(pndng), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single packet to (5,2) and its header layout
    drive(1, 5, 2, 1, 0, 15'h1234, 0);
    chk("t1_word", data_out, 32'h0052_9234);
    drive(0, 0, 0, 0, 0, 15'h0, 1);
    chk("t1_sent", 32'(sent_cnt), 32'd1);

    // Fill to full, attempt one more, then drain in order
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 2, 0, 0, 15'(i), 0);
    drive(1, 0, 2, 0, 0, 15'h7FFF, 0);
    chk("t2_full_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_order", 32'(data_out[14:0]), 32'(i));
      drive(0, 0, 0, 0, 0, 15'h0, 1);
    end

    // Invalid destinations: interior, out of range, self
    drive(1, 2, 2, 0, 0, 15'h1, 0);
    drive(1, 9, 1, 0, 0, 15'h2, 0);
    drive(1, 0, 1, 0, 0, 15'h3, 0);
    idle();
    chk("t3_dropcnt", 32'(drop_cnt), 32'd3);

    // Broadcast ignores row/col
    drive(1, 3, 3, 0, 1, 15'h55, 0);
    chk("t4_bcst_hdr", 32'(data_out[23:16]), 32'hFF);
    drive(0, 0, 0, 0, 0, 15'h0, 1);

    // Write and pop together at count 1
    drive(1, 1, 0, 0, 0, 15'h0AA, 0);
    drive(1, 4, 5, 1, 0, 15'h0BB, 1);
    chk("t5_newword", data_out, 32'h0045_80BB);

    // Asynchronous reset with packets queued
    for (int i = 0; i < 5; i++) drive(1, 5, 3, 0, 0, 15'(i + 100), 0);
    req_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pndng", 32'(pndng), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_dropcnt", 32'(drop_cnt), 32'd0);
    chk("t6_sentcnt", 32'(sent_cnt), 32'd0);
    mq.delete(); exp_drop = 0; exp_dropc = 0; exp_sent = 0;
    @(negedge clk) rst_n = 1'b1;
    drive(1, 0, 4, 1, 0, 15'h321, 0);
    drive(0, 0, 0, 0, 0, 15'h0, 1);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      int r, c;
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
      drive($urandom_range(0, 9) < 7, r, c, 1'($urandom), $urandom_range(0, 9) == 0,
            15'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
